// File: rtl/decomp_pkg.sv
// Shared types and helpers for the decompressor front end.
// Provides halfword/word widths, the instruction bundle type and the RVC length test.
package decomp_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] bits;
        logic              is_c;
    } instr_t;

    // RVC encodings use any low-bit pair other than 2'b11.
    function automatic bit is_compressed(logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fifo_instr_reader_if.sv
// Bus between the instruction FIFO, this reader and the decompressor.
// master: reader side (drives fifo_RD and instr_*); slave: FIFO/decompressor side.
interface fifo_instr_reader_if;
    import decomp_pkg::*;

    logic              EN;
    logic              flush;
    logic              fifo_EMPTY;
    logic [WORD_W-1:0] fifo_dataOut;
    logic              fifo_RD;
    logic [WORD_W-1:0] instr_out;
    logic              instr_is_c;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        input  EN,
        input  flush,
        input  fifo_EMPTY,
        input  fifo_dataOut,
        output fifo_RD,
        output instr_out,
        output instr_is_c,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        output EN,
        output flush,
        output fifo_EMPTY,
        output fifo_dataOut,
        input  fifo_RD,
        input  instr_out,
        input  instr_is_c,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/hw_align_buf.sv
// Four-halfword realignment buffer: shift out 0/1/2 consumed halfwords, then append a word.
// Ports: clk, rst, flush_i, consume_i (0..2), append_i, data_i -> hw0_o, hw1_o, count_o, count_after_o.
module hw_align_buf
    import decomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [1:0]        consume_i,
    input  logic              append_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [HW_W-1:0]   hw0_o,
    output logic [HW_W-1:0]   hw1_o,
    output logic [2:0]        count_o,
    output logic [2:0]        count_after_o
);

    // hw[i] lives at buf_q[16*i +: 16]; hw[0] is the oldest halfword.
    logic [4*HW_W-1:0] buf_q;
    logic [4*HW_W-1:0] buf_d;
    logic [2:0]        count_q;
    logic [2:0]        count_d;

    logic [4*HW_W-1:0] shifted;
    logic [4*HW_W-1:0] incoming;

    assign hw0_o   = buf_q[HW_W-1:0];
    assign hw1_o   = buf_q[2*HW_W-1:HW_W];
    assign count_o = count_q;

    // Slots at or above count are kept zero, so the append can be OR-ed in.
    always_comb begin
        count_after_o = count_q - {1'b0, consume_i};
        shifted       = buf_q >> {consume_i, 4'b0000};
        incoming      = '0;
        if (append_i) begin
            incoming = {{WORD_W{1'b0}}, data_i} << {count_after_o, 4'b0000};
        end
        buf_d   = shifted | incoming;
        count_d = count_after_o + (append_i ? 3'd2 : 3'd0);
        if (flush_i) begin
            buf_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_instr_reader.sv
// Read-side controller of the decompressor instruction FIFO: issues reads, realigns halfwords,
// and hands whole instructions out on a valid/ready handshake. Ports: clk, Rst, bus (master).
module fifo_instr_reader
    import decomp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BUF_HW = 4
) (
    input logic                 clk,
    input logic                 Rst,
    fifo_instr_reader_if.master bus
);

    if (WIDTH != WORD_W) begin : g_bad_width
        $error("fifo_instr_reader: WIDTH must be 32");
    end
    if (BUF_HW != 4) begin : g_bad_depth
        $error("fifo_instr_reader: BUF_HW must be 4");
    end

    logic              pending_q;
    logic              pending_d;
    logic [HW_W-1:0]   hw0;
    logic [HW_W-1:0]   hw1;
    logic [2:0]        count;
    logic [2:0]        count_after;
    logic [1:0]        consume;
    logic              append;
    logic              xfer;
    logic              head_c;
    logic              valid;
    instr_t            instr;

    hw_align_buf u_buf (
        .clk           (clk),
        .rst           (Rst),
        .flush_i       (bus.flush),
        .consume_i     (consume),
        .append_i      (append),
        .data_i        (bus.fifo_dataOut),
        .hw0_o         (hw0),
        .hw1_o         (hw1),
        .count_o       (count),
        .count_after_o (count_after)
    );

    always_comb begin
        head_c     = is_compressed(hw0);
        valid      = (count >= 3'd1 && head_c) || (count >= 3'd2);
        instr.bits = head_c ? {{HW_W{1'b0}}, hw0} : {hw1, hw0};
        instr.is_c = head_c && (count != 3'd0);
    end

    // flush outranks both the handshake and the returning read word.
    always_comb begin
        xfer    = valid && bus.instr_ready && bus.EN && !bus.flush;
        consume = 2'd0;
        if (xfer) begin
            consume = head_c ? 2'd1 : 2'd2;
        end
        append = pending_q && !bus.flush;
    end

    // Reserve room for a whole word after this cycle's consume; one read in flight at most.
    always_comb begin
        bus.fifo_RD = !Rst && bus.EN && !bus.flush && !bus.fifo_EMPTY
                      && !pending_q && (count_after <= 3'd2);
        pending_d   = bus.fifo_RD;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.instr_out   = instr.bits;
    assign bus.instr_is_c  = instr.is_c;
    assign bus.instr_valid = valid;

endmodule

// File: tb/tb_fifo_instr_reader.sv
// Testbench for fifo_instr_reader: queue-based halfword model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_instr_reader;
    import decomp_pkg::*;

    logic clk = 1'b0;
    logic Rst;

    fifo_instr_reader_if bus();

    fifo_instr_reader dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO model: registered read data one cycle after fifo_RD is sampled.
    logic [31:0] fifo_q[$];
    int          fifo_n = 0;

    assign bus.fifo_EMPTY = (fifo_n == 0);

    always @(posedge clk) begin
        if (bus.fifo_RD && fifo_q.size() > 0) begin
            bus.fifo_dataOut <= fifo_q.pop_front();
            fifo_n <= fifo_n - 1;
        end
    end

    task automatic push(logic [31:0] w);
        fifo_q.push_back(w);
        fifo_n = fifo_n + 1;
    endtask

    // Reference model: ordered halfword queue, one in-flight word.
    logic [15:0] mq[$];
    bit          m_pend = 0;
    logic [31:0] m_word = '0;
    bit          p_plan = 0;
    int          p_consume;
    bit          p_rd;
    bit          p_flush;
    bit          p_cap;
    logic [31:0] p_word;

    always @(negedge clk) begin
        bit          ev;
        bit          ec;
        logic [31:0] eo;
        int          after;
        bit          erd;
        if (!Rst) begin
            ev = 0;
            ec = 0;
            eo = '0;
            if (mq.size() >= 1) begin
                ec = (mq[0][1:0] != 2'b11);
                if (ec) eo = {16'h0000, mq[0]};
                else if (mq.size() >= 2) eo = {mq[1], mq[0]};
                ev = ec || (mq.size() >= 2);
            end
            chk("instr_valid", bus.instr_valid, ev);
            if (ev) begin
                chk("instr_out", bus.instr_out, eo);
                chk("instr_is_c", bus.instr_is_c, ec);
            end
            p_consume = (ev && bus.instr_ready && bus.EN && !bus.flush) ? (ec ? 1 : 2) : 0;
            after     = mq.size() - p_consume;
            erd       = bus.EN && !bus.flush && !bus.fifo_EMPTY && !m_pend && (after <= 2);
            chk("fifo_RD", bus.fifo_RD, erd);
            p_rd    = erd;
            p_word  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            p_flush = bus.flush;
            p_cap   = m_pend && !bus.flush;
            p_plan  = 1;
        end
    end

    always @(posedge clk) begin
        if (Rst) begin
            mq.delete();
            m_pend = 0;
            p_plan = 0;
        end else if (p_plan) begin
            if (p_flush) begin
                mq.delete();
                m_pend = 0;
            end else begin
                repeat (p_consume) void'(mq.pop_front());
                if (p_cap) begin
                    mq.push_back(m_word[15:0]);
                    mq.push_back(m_word[31:16]);
                end
                m_pend = p_rd;
                if (p_rd) m_word = p_word;
            end
            p_plan = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.instr_valid) break;
        end
        if (k == 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: instr_valid timeout, got 0 expected 1", nm);
        end
    endtask

    task automatic wait_rd(string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.fifo_RD) break;
        end
        if (k == 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: fifo_RD timeout, got 0 expected 1", nm);
        end
    endtask

    logic [15:0] t4_exp[6];
    logic [15:0] t4_got[$];

    initial begin
        Rst             = 1'b1;
        bus.EN          = 1'b1;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        #2;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_out", bus.instr_out, 0);
        chk("rst_is_c", bus.instr_is_c, 0);
        chk("rst_rd", bus.fifo_RD, 0);
        step();
        step();
        Rst = 1'b0;

        // 1: single 32-bit instruction
        push(32'h00130513);
        @(negedge clk);
        chk("t1_rd_pulse", bus.fifo_RD, 1);
        @(negedge clk);
        chk("t1_rd_low", bus.fifo_RD, 0);
        chk("t1_not_yet", bus.instr_valid, 0);
        @(negedge clk);
        chk("t1_valid", bus.instr_valid, 1);
        chk("t1_out", bus.instr_out, 32'h00130513);
        chk("t1_is_c", bus.instr_is_c, 0);
        @(negedge clk);
        chk("t1_taken", bus.instr_valid, 0);

        // 2: two compressed halves of one word
        step();
        push(32'h45014501);
        wait_valid("t2a");
        chk("t2a_out", bus.instr_out, 32'h00004501);
        chk("t2a_is_c", bus.instr_is_c, 1);
        @(negedge clk);
        chk("t2b_valid", bus.instr_valid, 1);
        chk("t2b_out", bus.instr_out, 32'h00004501);
        @(negedge clk);
        chk("t2_empty", bus.instr_valid, 0);

        // 3: 32-bit instruction split across two words
        step();
        push(32'h05134501);
        wait_valid("t3a");
        chk("t3a_out", bus.instr_out, 32'h00004501);
        chk("t3a_is_c", bus.instr_is_c, 1);
        @(negedge clk);
        chk("t3_held", bus.instr_valid, 0);
        step();
        push(32'h00000013);
        wait_valid("t3b");
        chk("t3b_out", bus.instr_out, 32'h00130513);
        chk("t3b_is_c", bus.instr_is_c, 0);
        step();
        step();

        // 4: backpressure with a full buffer
        bus.instr_ready = 1'b0;
        push(32'h00050001);
        push(32'h000d0009);
        push(32'h00150011);
        repeat (10) step();
        @(negedge clk);
        chk("t4_rd_blocked", bus.fifo_RD, 0);
        chk("t4_valid", bus.instr_valid, 1);
        chk("t4_out", bus.instr_out, 32'h00000001);
        step();
        step();
        @(negedge clk);
        chk("t4_stable", bus.instr_out, 32'h00000001);
        step();
        bus.instr_ready = 1'b1;
        t4_exp = '{16'h0001, 16'h0005, 16'h0009, 16'h000d, 16'h0011, 16'h0015};
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.instr_valid && bus.instr_ready) t4_got.push_back(bus.instr_out[15:0]);
        end
        chk("t4_count", t4_got.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < t4_got.size()) chk("t4_seq", {16'h0, t4_got[k]}, {16'h0, t4_exp[k]});
        end
        step();

        // 5: flush while a capture is pending
        push(32'h00090009);
        push(32'h000d000d);
        wait_rd("t5");
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("t5_rd_flush", bus.fifo_RD, 0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t5_valid_low", bus.instr_valid, 0);
        wait_valid("t5b");
        chk("t5_first", bus.instr_out, 32'h0000000d);
        repeat (4) step();

        // 6: reset mid-transfer with EN low during capture
        push(32'h00130513);
        push(32'h45014501);
        wait_rd("t6");
        step();
        bus.EN = 1'b0;
        step();
        chk("t6_captured", bus.instr_valid, 1);
        chk("t6_out", bus.instr_out, 32'h00130513);
        Rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.instr_valid, 0);
        chk("t6_rst_out", bus.instr_out, 0);
        chk("t6_rst_is_c", bus.instr_is_c, 0);
        chk("t6_rst_rd", bus.fifo_RD, 0);
        step();
        Rst    = 1'b0;
        bus.EN = 1'b1;
        wait_valid("t6b");
        chk("t6b_out", bus.instr_out, 32'h00004501);
        repeat (4) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if (Rst) Rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) Rst = 1'b1;
            bus.EN          = ($urandom_range(0, 9) != 0);
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.flush       = ($urandom_range(0, 39) == 0);
            if (fifo_n < 6 && $urandom_range(0, 2) == 0) push($urandom);
        end
        step();
        Rst             = 1'b0;
        bus.EN          = 1'b1;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
